// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mul/div sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } seq_state_t;

  localparam logic [31:0] DIVZERO_QUOT = 32'hFFFF_FFFF;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences one M-extension op through the fixed-latency mul/div unit and
// merges its result onto the regfile write port shared with commit.
//
// state | meaning
// IDLE  | no op pending, ready to accept
// BUSY  | unit running, counting down latency
// WB    | result held, waiting for a free write-port cycle
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        issue_stall,
  input  logic        kill,
  output logic        unit_start,
  output logic [2:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] unit_result,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wb,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  muldiv_op_t       op;
  logic [4:0]       rd;
  logic [31:0]      a, b, res;

  logic accept, div_zero, first_busy, own_write;

  assign accept     = (state == IDLE) && req_valid && !kill;
  assign div_zero   = is_div(req_op) && (req_b == 32'd0);
  assign first_busy = (cnt == (is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid) state_nxt = div_zero ? WB : BUSY;
        BUSY:    if (cnt == CNT_W'(1)) state_nxt = WB;
        WB:      if (!pipe_we || rd == 5'd0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      op  <= OP_MUL;
      rd  <= '0;
      a   <= '0;
      b   <= '0;
      res <= '0;
    end else if (accept) begin
      op  <= muldiv_op_t'(req_op);
      rd  <= req_rd;
      a   <= req_a;
      b   <= req_b;
      cnt <= div_zero ? '0 : (is_div(req_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT));
      // RISC-V divide-by-zero: quotient all ones, remainder is the dividend
      if (div_zero) res <= req_op[1] ? req_a : DIVZERO_QUOT;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) res <= unit_result;
    end
  end

  assign own_write = (state == WB) && !pipe_we && !kill && !rst && (rd != 5'd0);

  always_comb begin
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    unit_start  = (state == BUSY) && first_busy && !kill && !rst;
    unit_op     = op;
    unit_a      = a;
    unit_b      = b;
    hazard      = busy && (rd != 5'd0) && ((rs1 == rd) || (rs2 == rd));
    issue_stall = (req_valid && !req_ready) || hazard;
    wb_we       = pipe_we;
    wb_rd       = pipe_rd;
    wb_data     = pipe_wb;
    if (own_write) begin
      wb_we   = 1'b1;
      wb_rd   = rd;
      wb_data = res;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: a transaction-level model predicts every output each cycle.
module tb_muldiv_sequencer;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [31:0] req_a, req_b;
  logic        req_ready;
  logic [4:0]  rs1, rs2;
  logic        hazard, issue_stall, kill, unit_start;
  logic [2:0]  unit_op;
  logic [31:0] unit_a, unit_b, unit_result;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wb;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  muldiv_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .issue_stall(issue_stall), .kill(kill), .unit_start(unit_start),
    .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b), .unit_result(unit_result),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wb(pipe_wb), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: at most one op outstanding, tracked by cycle numbers.
  bit          m_pend = 0;
  bit          m_dz;
  int          m_acc, m_lat, m_done_min;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_a, m_b, m_res;

  logic        o_wb_we, o_busy, o_hazard, o_stall, o_ready;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  task automatic run_cycle(input logic v, input logic [2:0] op, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r1, input logic [4:0] r2, input logic kl,
                           input logic pwe, input logic [4:0] prd, input logic [31:0] pwb,
                           input logic rs);
    logic        e_start, e_hz, e_stall, mine, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    req_valid = v; req_op = op; req_rd = rd; req_a = a; req_b = b;
    rs1 = r1; rs2 = r2; kill = kl; pipe_we = pwe; pipe_rd = prd; pipe_wb = pwb; rst = rs;
    unit_result = (m_pend && !m_dz && cyc == m_acc + m_lat) ? m_res : $urandom;
    @(negedge clk);
    o_wb_we = wb_we; o_wb_rd = wb_rd; o_wb_data = wb_data;
    o_busy = busy; o_hazard = hazard; o_stall = issue_stall; o_ready = req_ready;

    e_start = m_pend && !m_dz && (cyc == m_acc + 1) && !kl && !rs;
    e_hz    = m_pend && (m_rd != 0) && (r1 == m_rd || r2 == m_rd);
    e_stall = (v && m_pend) || e_hz;
    mine    = m_pend && (cyc >= m_done_min) && !pwe && (m_rd != 0) && !kl && !rs;
    e_we    = mine ? 1'b1 : pwe;
    e_rd    = mine ? m_rd : prd;
    e_data  = mine ? m_res : pwb;

    n_checks++;
    if (busy !== m_pend || req_ready !== !m_pend) begin
      n_errors++;
      $display("FAIL busy/ready cyc=%0d: got busy=%b ready=%b, expected busy=%b", cyc, busy, req_ready, m_pend);
    end
    n_checks++;
    if (unit_start !== e_start) begin
      n_errors++;
      $display("FAIL unit_start cyc=%0d: got %b, expected %b", cyc, unit_start, e_start);
    end
    if (e_start) begin
      n_checks++;
      if (unit_op !== m_op || unit_a !== m_a || unit_b !== m_b) begin
        n_errors++;
        $display("FAIL unit_operands cyc=%0d: got op=%0d a=%h b=%h, expected op=%0d a=%h b=%h",
                 cyc, unit_op, unit_a, unit_b, m_op, m_a, m_b);
      end
    end
    n_checks++;
    if (hazard !== e_hz || issue_stall !== e_stall) begin
      n_errors++;
      $display("FAIL hazard/stall cyc=%0d: got %b/%b, expected %b/%b", cyc, hazard, issue_stall, e_hz, e_stall);
    end
    n_checks++;
    if (wb_we !== e_we || (e_we && (wb_rd !== e_rd || wb_data !== e_data))) begin
      n_errors++;
      $display("FAIL writeback cyc=%0d: got we=%b rd=%0d data=%h, expected we=%b rd=%0d data=%h",
               cyc, wb_we, wb_rd, wb_data, e_we, e_rd, e_data);
    end

    @(posedge clk);
    #1;
    if (rs || kl) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (cyc >= m_done_min && (!pwe || m_rd == 0)) m_pend = 0;
    end else if (v) begin
      m_pend = 1; m_acc = cyc; m_op = op; m_rd = rd; m_a = a; m_b = b;
      m_dz  = (op >= 4) && (b == 0);
      m_lat = (op >= 4) ? DIV_LAT : MUL_LAT;
      m_done_min = m_dz ? cyc + 1 : cyc + m_lat + 1;
      if (m_dz) m_res = (op >= 6) ? a : 32'hFFFF_FFFF;
      else      m_res = $urandom;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic pwe);
    for (int i = 0; i < n; i++)
      run_cycle(0, 3'($urandom), 5'($urandom), $urandom, $urandom, 5'd31, 5'd31, 0,
                pwe, 5'($urandom), $urandom, 0);
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 0; kill = 0; pipe_we = 0; pipe_rd = 0; pipe_wb = 0;
    req_op = 0; req_rd = 0; req_a = 0; req_b = 0; rs1 = 0; rs2 = 0; unit_result = 0;
    repeat (2) @(posedge clk);
    #1;
    idle(1, 0);
    n_checks++;
    if (unit_op !== 3'd0 || unit_a !== 32'd0 || unit_b !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_regs: got op=%0d a=%h b=%h, expected all zero", unit_op, unit_a, unit_b);
    end
  endtask

  task automatic test_mul;
    run_cycle(1, 3'd0, 5'd5, 32'd6, 32'd7, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    m_res = 32'd42;
    idle(4, 0);
    n_checks++;
    if (o_wb_we !== 1'b1 || o_wb_rd !== 5'd5 || o_wb_data !== 32'd42) begin
      n_errors++;
      $display("FAIL mul_wb: got we=%b rd=%0d data=%h, expected 1/5/0000002a", o_wb_we, o_wb_rd, o_wb_data);
    end
    idle(1, 0);
  endtask

  task automatic test_divzero;
    run_cycle(1, 3'd5, 5'd8, 32'd100, 32'd0, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    idle(1, 0);
    n_checks++;
    if (o_wb_we !== 1'b1 || o_wb_rd !== 5'd8 || o_wb_data !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL divu_zero: got we=%b rd=%0d data=%h, expected 1/8/ffffffff", o_wb_we, o_wb_rd, o_wb_data);
    end
    run_cycle(1, 3'd6, 5'd9, 32'hFFFF_FFF7, 32'd0, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    idle(1, 0);
    n_checks++;
    if (o_wb_we !== 1'b1 || o_wb_data !== 32'hFFFF_FFF7) begin
      n_errors++;
      $display("FAIL rem_zero: got we=%b data=%h, expected 1/fffffff7", o_wb_we, o_wb_data);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] tok;
    run_cycle(1, 3'd4, 5'd3, 32'd1000, 32'd7, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    tok = m_res;
    idle(DIV_LAT, 0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 0, 0, 5'd31, 5'd31, 0, 1, 5'd2, 32'h11, 0);
      n_checks++;
      if (o_wb_we !== 1'b1 || o_wb_rd !== 5'd2 || o_wb_data !== 32'h11 || o_busy !== 1'b1) begin
        n_errors++;
        $display("FAIL pipe_priority[%0d]: got we=%b rd=%0d data=%h busy=%b, expected 1/2/00000011/1",
                 i, o_wb_we, o_wb_rd, o_wb_data, o_busy);
      end
    end
    idle(1, 0);
    n_checks++;
    if (o_wb_we !== 1'b1 || o_wb_rd !== 5'd3 || o_wb_data !== tok) begin
      n_errors++;
      $display("FAIL div_retry_wb: got we=%b rd=%0d data=%h, expected 1/3/%h", o_wb_we, o_wb_rd, o_wb_data, tok);
    end
    idle(1, 0);
  endtask

  task automatic test_hazard;
    run_cycle(1, 3'd1, 5'd10, $urandom, 32'd3, 5'd10, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    for (int i = 0; i < MUL_LAT + 1; i++) begin
      run_cycle(1, 3'd0, 5'd1, 0, 1, 5'd10, 5'd0, 0, 0, 5'd0, 32'd0, 0);
      n_checks++;
      if (o_hazard !== 1'b1 || o_stall !== 1'b1) begin
        n_errors++;
        $display("FAIL hazard_rd10[%0d]: got hazard=%b stall=%b, expected 1/1", i, o_hazard, o_stall);
      end
    end
    run_cycle(1, 3'd0, 5'd0, 32'd2, 32'd3, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    for (int i = 0; i < MUL_LAT + 1; i++) begin
      run_cycle(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'($urandom), $urandom, 0);
      n_checks++;
      if (o_hazard !== 1'b0 || o_wb_we !== 1'b0) begin
        n_errors++;
        $display("FAIL rd0[%0d]: got hazard=%b wb_we=%b, expected 0/0", i, o_hazard, o_wb_we);
      end
    end
  endtask

  task automatic test_kill;
    run_cycle(1, 3'd7, 5'd12, 32'd50, 32'd9, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    idle(1, 0);
    run_cycle(0, 0, 0, 0, 0, 5'd31, 5'd31, 1, 0, 5'd0, 32'd0, 0);
    idle(1, 0);
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL kill_idle: got ready=%b busy=%b, expected 1/0", o_ready, o_busy);
    end
    idle(DIV_LAT + 2, 0);
    run_cycle(1, 3'd0, 5'd4, 1, 1, 5'd0, 5'd0, 1, 0, 5'd0, 32'd0, 0);
    idle(1, 0);
  endtask

  task automatic test_reset_wb;
    run_cycle(1, 3'd4, 5'd6, 32'd1, 32'd0, 5'd0, 5'd0, 0, 0, 5'd0, 32'd0, 0);
    run_cycle(0, 0, 0, 0, 0, 5'd31, 5'd31, 0, 1, 5'd1, 32'h22, 0);
    run_cycle(0, 0, 0, 0, 0, 5'd31, 5'd31, 0, 1, 5'd1, 32'h33, 1);
    run_cycle(0, 0, 0, 0, 0, 5'd31, 5'd31, 0, 0, 5'd7, 32'h44, 0);
    n_checks++;
    if (o_busy !== 1'b0 || o_wb_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_wb: got busy=%b wb_we=%b, expected 0/0", o_busy, o_wb_we);
    end
  endtask

  task automatic test_random;
    logic [31:0] b;
    for (int i = 0; i < 1500; i++) begin
      b = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      run_cycle($urandom_range(1), 3'($urandom), 5'($urandom_range(7)), $urandom, b,
                5'($urandom_range(7)), 5'($urandom_range(7)), ($urandom_range(39) == 0),
                ($urandom_range(2) == 0), 5'($urandom), $urandom, ($urandom_range(99) == 0));
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_divzero;
    test_arbitration;
    test_hazard;
    test_kill;
    test_reset_wb;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
